// File: rtl/seq_det_ctrl.sv
// Programmable serial-pattern detector: runtime pattern/length, overlap mode,
// match counting with an optional stop target, and guarded config writes.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_wr,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_target,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         in_valid,
    input  logic                         in_bit,
    output logic                         match,
    output logic [CNT_W-1:0]             match_cnt,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int LEN_W1 = LEN_W + 1;
    localparam int CNT_W1 = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [MAX_LEN-1:0]   r_pattern;
    logic [LEN_W-1:0]     r_len;
    logic                 r_overlap;
    logic [CNT_W-1:0]     r_target;
    // Only MAX_LEN-1 history bits are kept; the incoming bit completes the window.
    logic [MAX_LEN-2:0]   r_window;
    logic [LEN_W-1:0]     r_fill;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_match;
    logic                 r_cfg_err;

    logic                 w_cfg_len_ok;
    logic                 w_cfg_accept;
    logic [MAX_LEN-1:0]   w_win_next;
    logic [MAX_LEN-1:0]   w_mask;
    logic                 w_pat_eq;
    logic [LEN_W:0]       w_fill_p1;
    logic                 w_fill_ok;
    logic [LEN_W-1:0]     w_fill_sat;
    logic                 w_hit;
    logic [CNT_W:0]       w_cnt_p1;
    logic                 w_hits_target;
    logic                 w_clear;
    logic                 w_shift;
    logic                 w_detect;

    assign w_cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign w_cfg_accept = cfg_wr && (r_state != ST_ARMED) && w_cfg_len_ok;

    assign w_win_next = {r_window, in_bit};

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_mask
            assign w_mask[gi] = (LEN_W'(gi) < r_len);
        end
    endgenerate

    assign w_pat_eq      = ((w_win_next ^ r_pattern) & w_mask) == '0;
    assign w_fill_p1     = {1'b0, r_fill} + LEN_W1'(1);
    assign w_fill_ok     = w_fill_p1 >= {1'b0, r_len};
    assign w_fill_sat    = (r_fill == LEN_W'(MAX_LEN)) ? r_fill : w_fill_p1[LEN_W-1:0];
    assign w_hit         = w_pat_eq && w_fill_ok;
    assign w_cnt_p1      = {1'b0, r_cnt} + CNT_W1'(1);
    assign w_hits_target = (r_target != '0) && (w_cnt_p1 == {1'b0, r_target});
    assign w_detect      = w_shift && w_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority: abort, then start, then the qualified serial bit.
    always_comb begin
        w_state_next = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        if (abort) begin
            w_state_next = ST_IDLE;
        end else if (start) begin
            w_state_next = ST_ARMED;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (in_valid) begin
                        w_shift = 1'b1;
                        if (w_hit && w_hits_target) begin
                            w_state_next = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_cfg_accept) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= MAX_LEN'(4'b1011);
            r_len     <= LEN_W'(4);
            r_overlap <= 1'b1;
            r_target  <= '0;
            r_window  <= '0;
            r_fill    <= '0;
            r_cnt     <= '0;
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_match   <= w_detect;
            r_cfg_err <= cfg_wr && !w_cfg_accept;
            if (w_cfg_accept) begin
                r_pattern <= cfg_pattern;
                r_len     <= cfg_len;
                r_overlap <= cfg_overlap;
                r_target  <= cfg_target;
            end
            if (w_clear) begin
                r_window <= '0;
                r_fill   <= '0;
                r_cnt    <= '0;
            end else if (w_shift) begin
                r_window <= w_win_next[MAX_LEN-2:0];
                if (w_hit) begin
                    // Non-overlap mode forces the next match to use fresh bits only.
                    r_fill <= r_overlap ? w_fill_sat : '0;
                    if (r_cnt != '1) begin
                        r_cnt <= w_cnt_p1[CNT_W-1:0];
                    end
                end else begin
                    r_fill <= w_fill_sat;
                end
            end
        end
    end

    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign busy      = (r_state == ST_ARMED);
    assign done      = (r_state == ST_DONE);
    assign cfg_err   = r_cfg_err;

endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Programmable serial-pattern detection controller. It holds a runtime-configured bit pattern of 1..MAX_LEN bits and arms/disarms detection on a qualified serial bit stream. It counts matches, in overlapping or non-overlapping mode, and stops after a programmed number of matches. It sits between the control/config logic and the serial input path, replacing fixed hard-coded pattern detectors.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cfg_wr  input  1  config write strobe
cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected
cfg_len  input  $clog2(MAX_LEN+1)  pattern length, valid range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping matches allowed
cfg_target  input  CNT_W  matches before stop; 0 = unlimited
start  input  1  arm detection (pulse)
abort  input  1  disarm, return to IDLE (pulse)
in_valid  input  1  in_bit qualifier
in_bit  input  1  serial data bit
match  output  1  one-cycle pulse per detected match
match_cnt  output  CNT_W  matches since last start
busy  output  1  high in ARMED
done  output  1  high in DONE
cfg_err  output  1  one-cycle pulse on rejected config write

Behaviour:
- Clock port is clk; reset port is rst. Single clock domain; reset is synchronous and active-high.
- Reset values:
  - Outputs: match=0, match_cnt=0, busy=0, done=0, cfg_err=0.
  - State: IDLE.
  - Config registers: pattern=...1011, len=4, overlap=1, target=0.
  - Window and fill counter: 0.
- States:
  - IDLE: not detecting, in_valid ignored.
  - ARMED: detecting.
  - DONE: target reached, in_valid ignored.
- Transitions:
  - IDLE/DONE, start -> ARMED. Clears window, fill and match_cnt; done drops on the same edge.
  - ARMED, start -> ARMED restart: same clearing, current in_bit discarded.
  - Any state, abort -> IDLE. match_cnt is held; done clears.
  - ARMED, match with target!=0 and match_cnt+1 == target -> DONE.
- Priority within one cycle: rst > abort > start > in_valid bit.
- Config:
  - cfg_wr is accepted only in IDLE or DONE, and only when 1 <= cfg_len <= MAX_LEN. All four cfg fields latch together on that edge.
  - A cfg_wr in DONE also moves the state to IDLE.
  - Any rejected cfg_wr (ARMED state or illegal len) leaves the config unchanged and pulses cfg_err on the next cycle.
- Detection (ARMED, in_valid=1):
  - Window shifts left with in_bit entering the LSB.
  - fill increments, saturating at MAX_LEN.
  - A match occurs when fill+1 >= len and the low len bits of the new window equal pattern[len-1:0].
  - Bits with in_valid=0 are ignored and do not reset the window.
- Match response:
  - match is registered: high exactly the cycle after the edge that sampled the completing bit.
  - match_cnt increments on that same edge and saturates at all-ones (target=0 case).
- Overlap:
  - overlap=1: window and fill kept after a match, so suffixes can start the next match.
  - overlap=0: fill cleared to 0 on a match, so the next match needs len fresh bits.
- A match on the edge entering DONE is still pulsed and counted. No further matches occur until the next start.
- Bit order: the first bit received aligns to pattern MSB (pattern[len-1]).

Test Plan:
- Default config, start, stream 1,0,1,1,0,1,1 (in_valid=1 every cycle) -> match pulses after bits 4 and 7; match_cnt=2; busy=1, done=0.
- cfg_overlap=0 with pattern 1011, same stream -> single match after bit 4; match_cnt=1.
- cfg_pattern=11, len=2, overlap=1, stream 1,1,1,1 -> 3 matches. With overlap=0 -> 2 matches (after bits 2 and 4).
- target=2, default pattern, stream 1011 1011 1011 -> match after bits 4 and 8; done=1 and busy=0 from the cycle after bit 8; third 1011 not counted; match_cnt=2. A subsequent start clears match_cnt to 0 and done to 0.
- Illegal and blocked config:
  - cfg_wr with cfg_len=0 in IDLE -> cfg_err pulse, config unchanged (pattern 1011 still detected).
  - cfg_wr while ARMED -> cfg_err pulse, detection unaffected.
- Abort and restart:
  - abort after bits 1,0,1 then start, stream 1 -> no match; match_cnt=0.
  - start asserted together with in_valid=1 mid-stream -> that bit discarded, window cleared.
  - rst asserted mid-stream -> all outputs 0, config back to 1011/len 4.
